tag_meta_array: RTL and testbench
=================================

Name: tag_meta_array

Overview:
- Parametrised set-associative tag/metadata store. Next generation of the flat one-hot-enabled metadata array.
- Adds per-way valid bits, registered tag compare, victim selection, single-set invalidate and a full-array invalidate sweep.
- Sits beside the cache data array and is driven by the cache controller FSM through a single command port.

Parameters:
- NUM_SETS, 64, number of sets; power of 2, at least 2. IDX_W = log2(NUM_SETS).
- WAYS, 2, associativity; allowed values 1, 2, 4. WAY_W = max(1, log2(WAYS)).
- TAG_W, 8, tag width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  command opcode: 00 lookup, 01 fill, 10 invalidate set, 11 invalidate all.
- cmd_index  in  IDX_W  set index.
- cmd_tag  in  TAG_W  tag for lookup or fill.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  WAY_W  matched way (hit) or written way (fill).
- rsp_evict  out  1  fill replaced a valid entry.
- rsp_evict_tag  out  TAG_W  tag of the evicted entry.
- busy  out  1  invalidate-all sweep in progress.

Behaviour:
- Reset (rst low, asynchronous): all valid bits 0, all round-robin pointers 0, FSM to IDLE, all outputs 0 except cmd_ready = 1. Tag storage is not cleared.
- FSM IDLE:
  - cmd_ready = 1; exactly one command is accepted per cycle.
  - The response is registered: rsp_valid = 1 in the cycle after acceptance, for exactly 1 cycle.
  - Response fields hold their values until the next response.
- Lookup:
  - Compare cmd_tag against every valid way of cmd_index.
  - Hit: rsp_hit = 1, rsp_way = lowest matching way.
  - Miss: rsp_hit = 0, rsp_way = 0.
  - No state change.
- Fill:
  - If cmd_tag is already valid in the set, rewrite that way. rsp_hit = 1, rsp_evict = 0, pointer unchanged.
  - Else if any way is invalid, write the lowest invalid way. rsp_evict = 0, pointer unchanged.
  - Else write the way at the set's round-robin pointer. rsp_evict = 1, rsp_evict_tag = the old tag, and the pointer increments modulo WAYS.
  - The written way's valid bit is set. rsp_way = the written way.
  - WAYS = 1 always uses way 0.
- Invalidate set:
  - Clear all valid bits of cmd_index and reset its pointer to 0.
  - Response: rsp_hit = 0, rsp_evict = 0.
- Invalidate all: move to SWEEP; busy = 1, cmd_ready = 0.
- FSM SWEEP:
  - A counter starting at 0 clears one set per cycle (valids and pointer).
  - After set NUM_SETS-1 is cleared, return to IDLE with rsp_valid = 1 in the same cycle busy falls.
  - The sweep lasts NUM_SETS cycles.
  - cmd_valid is ignored during SWEEP.
- Ordering: a write takes effect at the acceptance edge, so a command in cycle N+1 sees a fill or invalidate accepted in cycle N.
- Reset asserted mid-sweep: returns to IDLE immediately; all valids are 0 after reset regardless of sweep progress.

Optional Feature:
- TAG_META_PARITY_EN defined:
  - Each entry stores an even-parity bit over its tag, written on fill.
  - A lookup compare on a valid way with a parity mismatch is forced to miss, and that way's valid bit is cleared at the next edge.
  - Extra output port parity_err (1 bit) pulses alongside rsp_valid when any mismatch was detected. Reset value 0.
- Undefined: no parity storage, no parity_err port, behaviour otherwise identical.

Test Plan:
- Reset, then lookup index 5 tag 0x3A -> rsp_valid one cycle later, rsp_hit = 0, cmd_ready = 1.
- Fill index 5 tag 0x3A, then lookup index 5 tag 0x3A -> fill response rsp_way = 0, rsp_evict = 0; lookup response rsp_hit = 1, rsp_way = 0.
- WAYS = 2: fill index 7 with tags 0x11, 0x22, 0x33, 0x44 -> ways 0, 1, 0, 1.
  - Third fill: rsp_evict = 1, rsp_evict_tag = 0x11.
  - Fourth fill: rsp_evict_tag = 0x22.
- Fill index 7 tag 0x33 again -> rsp_hit = 1, rsp_way = 0, rsp_evict = 0; pointer unchanged, so the next new-tag fill goes to way 0.
- Populate sets 0 and 63, issue invalidate-all with cmd_valid held high -> busy = 1 for 64 cycles, no other command accepted, rsp_valid when busy falls; then lookups of both sets miss.
- Start invalidate-all, pulse rst low at sweep cycle 10 -> busy = 0 and cmd_ready = 1 immediately; lookups of previously filled sets 40 and 60 miss.

Source files
------------

// File: rtl/tag_meta_array.sv
// tag_meta_array: set-associative tag/metadata store that sits next to the
// cache data array. One command port from the cache controller:
//   op 00 lookup, 01 fill, 10 invalidate set, 11 invalidate all (sweep).
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_index, cmd_tag   command in
//   rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag  registered response
//   busy                                               sweep in progress
//   parity_err (only with TAG_META_PARITY_EN)          tag parity mismatch seen
// Optional feature macro: TAG_META_PARITY_EN adds an even-parity bit per
// entry; a lookup that finds a corrupted valid way treats it as a miss and
// drops its valid bit.

module tag_meta_way #(
  parameter int TAG_W = 8
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_st,
  input  logic [TAG_W-1:0] tag_in,
`ifdef TAG_META_PARITY_EN
  input  logic             par_st,
  output logic             perr,
`endif
  output logic             match
);
`ifdef TAG_META_PARITY_EN
  assign perr  = vld & (par_st != ^tag_st);
  assign match = vld & ~perr & (tag_st == tag_in);
`else
  assign match = vld & (tag_st == tag_in);
`endif
endmodule

module tag_meta_array #(
  parameter  int NUM_SETS = 64,
  parameter  int WAYS     = 2,
  parameter  int TAG_W    = 8,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_index,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_evict,
  output logic [TAG_W-1:0] rsp_evict_tag,
`ifdef TAG_META_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);
  localparam logic [1:0] OP_LOOKUP = 2'b00, OP_FILL = 2'b01,
                         OP_INVSET = 2'b10, OP_INVALL = 2'b11;

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]                swp_cnt;
  logic [NUM_SETS-1:0][WAYS-1:0]   vld;
  logic [NUM_SETS-1:0][WAY_W-1:0]  rr_ptr;
  logic [TAG_W-1:0]                tag_mem [NUM_SETS][WAYS];

  logic                   accept, swp_last;
  logic [WAYS-1:0]        set_vld, match;
  logic [WAYS-1:0][TAG_W-1:0] rd_tag;
  logic                   hit_any, inv_any, evict;
  logic [WAY_W-1:0]       hit_way, inv_way, wr_way;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == SWEEP);
  assign accept    = cmd_valid & cmd_ready;
  assign set_vld   = vld[cmd_index];
  assign swp_last  = (swp_cnt == IDX_W'(NUM_SETS - 1));

`ifdef TAG_META_PARITY_EN
  logic            par_mem [NUM_SETS][WAYS];
  logic [WAYS-1:0] perr;
`endif

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign rd_tag[w] = tag_mem[cmd_index][w];
    tag_meta_way #(.TAG_W(TAG_W)) u_way (
      .vld    (set_vld[w]),
      .tag_st (rd_tag[w]),
      .tag_in (cmd_tag),
`ifdef TAG_META_PARITY_EN
      .par_st (par_mem[cmd_index][w]),
      .perr   (perr[w]),
`endif
      .match  (match[w])
    );
  end

  // Way selection: existing copy first, then lowest free way, else the
  // round-robin victim. Loops run high-to-low so the lowest index wins.
  always_comb begin
    hit_any = |match;
    inv_any = ~&set_vld;
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])    hit_way = WAY_W'(w);
      if (!set_vld[w]) inv_way = WAY_W'(w);
    end
    evict = 1'b0;
    if (hit_any)      wr_way = hit_way;
    else if (inv_any) wr_way = inv_way;
    else begin
      wr_way = (WAYS == 1) ? '0 : rr_ptr[cmd_index];
      evict  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && cmd_op == OP_INVALL) state_nxt = SWEEP;
      SWEEP: if (swp_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld           <= '0;
      rr_ptr        <= '0;
      swp_cnt       <= '0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_way       <= '0;
      rsp_evict     <= 1'b0;
      rsp_evict_tag <= '0;
`ifdef TAG_META_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef TAG_META_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state == SWEEP) begin
        vld[swp_cnt]    <= '0;
        rr_ptr[swp_cnt] <= '0;
        swp_cnt         <= swp_cnt + 1'b1;
        if (swp_last) begin
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_way   <= '0;
          rsp_evict <= 1'b0;
        end
      end else if (accept) begin
        case (cmd_op)
          OP_LOOKUP: begin
            rsp_valid <= 1'b1;
            rsp_hit   <= hit_any;
            rsp_way   <= hit_any ? hit_way : '0;
            rsp_evict <= 1'b0;
`ifdef TAG_META_PARITY_EN
            vld[cmd_index] <= set_vld & ~perr;
            parity_err     <= |perr;
`endif
          end
          OP_FILL: begin
            rsp_valid <= 1'b1;
            rsp_hit   <= hit_any;
            rsp_way   <= wr_way;
            rsp_evict <= evict;
            vld[cmd_index][wr_way] <= 1'b1;
            if (evict) begin
              rsp_evict_tag     <= rd_tag[wr_way];
              rr_ptr[cmd_index] <= (WAYS == 1) ? '0 : rr_ptr[cmd_index] + 1'b1;
            end
          end
          OP_INVSET: begin
            rsp_valid         <= 1'b1;
            rsp_hit           <= 1'b0;
            rsp_way           <= '0;
            rsp_evict         <= 1'b0;
            vld[cmd_index]    <= '0;
            rr_ptr[cmd_index] <= '0;
          end
          default: swp_cnt <= '0;  // invalidate-all: response comes at sweep end
        endcase
      end
    end
  end

  // Tag storage is deliberately not reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (accept && cmd_op == OP_FILL) begin
      tag_mem[cmd_index][wr_way] <= cmd_tag;
`ifdef TAG_META_PARITY_EN
      par_mem[cmd_index][wr_way] <= ^cmd_tag;
`endif
    end
  end
endmodule

// File: tb/tb_tag_meta_array.sv
module tb_tag_meta_array;
  localparam int NUM_SETS = 64, WAYS = 2, TAG_W = 8;
  localparam int IDX_W = 6, WAY_W = 1;

  logic             clk = 1'b0, rst = 1'b0;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [IDX_W-1:0] cmd_index = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic             rsp_valid, rsp_hit, rsp_evict, busy;
  logic [WAY_W-1:0] rsp_way;
  logic [TAG_W-1:0] rsp_evict_tag;
`ifdef TAG_META_PARITY_EN
  logic             parity_err;
`endif

  always #5 clk = ~clk;

  tag_meta_array #(.NUM_SETS(NUM_SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag),
`ifdef TAG_META_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  typedef struct {
    string            nm;
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             chk_way;
    logic             ev;
    logic [TAG_W-1:0] evtag;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every response pulse consumes exactly one expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, ".hit"}, rsp_hit, e.hit);
        chk({e.nm, ".evict"}, rsp_evict, e.ev);
        if (e.chk_way) chk({e.nm, ".way"}, rsp_way, e.way);
        if (e.ev) chk({e.nm, ".evtag"}, rsp_evict_tag, e.evtag);
      end
    end
  end

  // Drives one command for one edge; leaves cmd_valid high so calls chain
  // back-to-back. push=0 for commands whose response is not expected.
  task automatic issue(input string nm, input logic [1:0] op, input int idx,
                       input logic [7:0] tag, input logic hit, input int way,
                       input logic chk_way, input logic ev, input logic [7:0] evtag,
                       input logic push = 1'b1);
    exp_t e;
    chk({nm, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_index = IDX_W'(idx); cmd_tag = tag;
    e.nm = nm; e.hit = hit; e.way = WAY_W'(way); e.chk_way = chk_way;
    e.ev = ev; e.evtag = evtag;
    if (push) q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic lookup(input string nm, input int idx, input logic [7:0] tag,
                        input logic hit, input int way);
    issue(nm, 2'b00, idx, tag, hit, way, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic fill(input string nm, input int idx, input logic [7:0] tag,
                      input logic hit, input int way, input logic ev, input logic [7:0] evtag);
    issue(nm, 2'b01, idx, tag, hit, way, 1'b1, ev, evtag);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    #12 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset.ready", cmd_ready, 1);
    chk("reset.busy", busy, 0);
    chk("reset.rsp_valid", rsp_valid, 0);

    lookup("lk5_miss", 5, 8'h3A, 0, 0);
    fill("fill5", 5, 8'h3A, 0, 0, 0, 8'h00);
    lookup("lk5_hit", 5, 8'h3A, 1, 0);

    // Round-robin replacement in a 2-way set.
    fill("f7_11", 7, 8'h11, 0, 0, 0, 8'h00);
    fill("f7_22", 7, 8'h22, 0, 1, 0, 8'h00);
    fill("f7_33", 7, 8'h33, 0, 0, 1, 8'h11);
    fill("f7_44", 7, 8'h44, 0, 1, 1, 8'h22);
    fill("f7_33again", 7, 8'h33, 1, 0, 0, 8'h00);
    fill("f7_55", 7, 8'h55, 0, 0, 1, 8'h33);
    lookup("lk7_44", 7, 8'h44, 1, 1);
    lookup("lk7_55", 7, 8'h55, 1, 0);
    lookup("lk7_33", 7, 8'h33, 0, 0);

    // Invalidate set clears valids and the pointer.
    issue("inv7", 2'b10, 7, 8'h00, 0, 0, 1'b0, 0, 8'h00);
    lookup("lk7_after_inv", 7, 8'h44, 0, 0);
    fill("f7_66", 7, 8'h66, 0, 0, 0, 8'h00);
    fill("f7_77", 7, 8'h77, 0, 1, 0, 8'h00);
    fill("f7_88", 7, 8'h88, 0, 0, 1, 8'h66);
    lookup("lk5_still", 5, 8'h3A, 1, 0);

    // Full sweep with cmd_valid held high the whole time.
    fill("f0", 0, 8'hA0, 0, 0, 0, 8'h00);
    fill("f63", 63, 8'hB0, 0, 0, 0, 8'h00);
    issue("invall", 2'b11, 0, 8'h00, 0, 0, 1'b0, 0, 8'h00);
    cmd_op = 2'b01; cmd_index = 6'd1; cmd_tag = 8'hCC;
    cnt = 0;
    while (busy && cnt < 200) begin
      if (cmd_ready) chk("sweep.ready_low", cmd_ready, 0);
      cnt++;
      @(posedge clk); #1;
    end
    chk("sweep.busy_cycles", cnt, 64);
    chk("sweep.rsp_at_busy_fall", rsp_valid, 1);
    cmd_valid = 1'b0;
    lookup("lk0_swept", 0, 8'hA0, 0, 0);
    lookup("lk63_swept", 63, 8'hB0, 0, 0);
    lookup("lk1_not_filled", 1, 8'hCC, 0, 0);
    lookup("lk5_swept", 5, 8'h3A, 0, 0);

    // Reset in the middle of a sweep.
    fill("f40", 40, 8'h40, 0, 0, 0, 8'h00);
    fill("f60", 60, 8'h60, 0, 0, 0, 8'h00);
    lookup("lk40_hit", 40, 8'h40, 1, 0);
    issue("invall2", 2'b11, 0, 8'h00, 0, 0, 1'b0, 0, 8'h00, 1'b0);
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.ready", cmd_ready, 1);
    chk("midrst.rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    lookup("lk40_reset", 40, 8'h40, 0, 0);
    lookup("lk60_reset", 60, 8'h60, 0, 0);
    idle(4);
    chk("pending_rsp", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
